uart_rx_fifo_feeder: RTL

Serial UART receiver that sits directly downstream of the UART transmitter on the FPGA side. It oversamples the incoming serial line on the system clock, recovers 8-bit frames (start, 8 data LSB-first, optional parity, stop), and presents each byte to the receive FIFO's write port through a valid/ready handshake. It also reports framing, parity and overrun errors.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_fifo_feeder_sync2.sv | 24 ++
 rtl/uart_rx_fifo_feeder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, receiver FSM states, and the even-parity helper
// that the transmitter also uses.
package uart_pkg;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/uart_rx_fifo_feeder_sync2.sv
// Two-flop synchronizer. Both flops reset to RST_VAL so that an idle-high line
// does not look like an edge when reset is released.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/uart_rx_fifo_feeder.sv
// Oversampling UART receiver that feeds bytes into a FIFO over valid/ready.
// Define UART_RX_PARITY_EN to expect one even-parity bit after data bit 7.
module uart_rx_fifo_feeder
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun,
  output logic              busy
);
  localparam int CW = 16;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic rx_s;
  sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst_n(rst), .d(rx), .q(rx_s));

  rx_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] shr_q, shr_d, data_q, data_d;
  logic              prev_q, valid_q, valid_d, fe_q, fe_d, pe_q, pe_d;
  logic              ov_q, ov_d, busy_q, busy_d, perr;
`ifdef UART_RX_PARITY_EN
  logic              par_q, par_d;
  assign perr = par_q != even_parity(shr_q);
`else
  assign perr = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shr_d   = shr_q;
    data_d  = data_q;
    valid_d = valid_q & ~rx_ready;
    fe_d    = 1'b0;
    pe_d    = 1'b0;
    ov_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: if (prev_q && !rx_s) begin
        state_d = ST_START;
        cnt_d   = HALF;
      end
      ST_START: if (cnt_q == '0) begin
        if (rx_s) state_d = ST_IDLE;
        else begin
          state_d = ST_DATA;
          idx_d   = '0;
          cnt_d   = FULL;
        end
      end else cnt_d = cnt_q - 1'b1;
      ST_DATA: if (cnt_q == '0) begin
        shr_d[idx_q] = rx_s;
        idx_d        = idx_q + 3'd1;
        cnt_d        = FULL;
`ifdef UART_RX_PARITY_EN
        if (idx_q == 3'd7) state_d = ST_PARITY;
`else
        if (idx_q == 3'd7) state_d = ST_STOP;
`endif
      end else cnt_d = cnt_q - 1'b1;
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (cnt_q == '0) begin
        par_d   = rx_s;
        cnt_d   = FULL;
        state_d = ST_STOP;
      end else cnt_d = cnt_q - 1'b1;
`endif
      ST_STOP: if (cnt_q == '0) begin
        state_d = ST_IDLE;
        if (!rx_s)     fe_d = 1'b1;
        else if (perr) pe_d = 1'b1;
        // A slot freed by this cycle's transfer can take the new byte directly.
        else if (!valid_q || rx_ready) begin
          data_d  = shr_q;
          valid_d = 1'b1;
        end else ov_d = 1'b1;
      end else cnt_d = cnt_q - 1'b1;
      default: state_d = ST_IDLE;
    endcase
    busy_d = state_d != ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shr_q   <= '0;
      data_q  <= '0;
      prev_q  <= 1'b1;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shr_q   <= shr_d;
      data_q  <= data_d;
      prev_q  <= rx_s;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = fe_q;
  assign parity_err = pe_q;
  assign overrun    = ov_q;
  assign busy       = busy_q;
endmodule
